// File: rtl/note_scroll_pkg.sv
// Shared definitions for the note lane scroller: FSM state encoding, default widths
// agreed with the LED driver and song ROM, and window row/lane bit-index helpers.
package note_scroll_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRIME = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } scroll_state_e;

  localparam int DEF_LANES    = 2;
  localparam int DEF_DEPTH    = 10;
  localparam int DEF_SUBSTEPS = 7;
  localparam int DEF_JUDGE    = 1;
  localparam int DEF_ADDR_W   = 11;
  localparam int DEF_TICK_W   = 17;
  localparam int DEF_COMBO_W  = 8;
  localparam int OFFSET_W     = 3;

  // Window layout: row r, lane i lives at bit r*lanes + i.
  function automatic int row_lsb(input int row, input int lanes);
    return row * lanes;
  endfunction

  function automatic int cell_bit(input int row, input int lane, input int lanes);
    return row * lanes + lane;
  endfunction

endpackage

// File: rtl/note_window_shift.sv
// Visible note window: DEPTH rows of LANES bits with shift/insert, judge-row clearing
// on hits, and miss detection for notes leaving row 0.
module note_window_shift
  import note_scroll_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int DEPTH = DEF_DEPTH,
  parameter int JUDGE = DEF_JUDGE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic                   hit_en_i,
  input  logic [LANES-1:0]       hit_i,
  input  logic                   shift_i,
  input  logic [LANES-1:0]       ins_i,
  output logic [DEPTH*LANES-1:0] win_o,
  output logic [LANES-1:0]       hit_mask_o,
  output logic                   miss_o,
  output logic                   empty_o
);

  localparam int W    = DEPTH * LANES;
  localparam int JLSB = row_lsb(JUDGE, LANES);

  logic [W-1:0] win_q;
  logic [W-1:0] win_d;
  logic [W-1:0] clr_mask;
  logic [W-1:0] cleared;

  // Hits clear the judge row first, so a hit cell shifted out the same cycle is not a miss.
  always_comb begin
    hit_mask_o             = hit_en_i ? (hit_i & win_q[JLSB +: LANES]) : '0;
    clr_mask               = '0;
    clr_mask[JLSB +: LANES] = hit_mask_o;
    cleared                = win_q & ~clr_mask;
    miss_o                 = shift_i && (|cleared[LANES-1:0]);
    win_d                  = cleared;
    if (clr_i) begin
      win_d = '0;
    end else if (shift_i) begin
      win_d = {ins_i, cleared[W-1:LANES]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q <= '0;
    end else begin
      win_q <= win_d;
    end
  end

  assign win_o   = win_q;
  assign empty_o = (win_q == '0);

endmodule

// File: rtl/note_lane_scroller.sv
// Rhythm-game note scroller: fetches chart steps from a 1-cycle sync ROM, scrolls them
// through the LED window with sub-row offset, judges hits/misses and tracks combo.
// Optional NOTE_SCROLL_PAUSE_EN adds a `pause` input that freezes scrolling in RUN/DRAIN.
module note_lane_scroller
  import note_scroll_pkg::*;
#(
  parameter int LANES    = DEF_LANES,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int SUBSTEPS = DEF_SUBSTEPS,
  parameter int JUDGE    = DEF_JUDGE,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int TICK_W   = DEF_TICK_W,
  parameter int COMBO_W  = DEF_COMBO_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      chart_len,
  input  logic [TICK_W-1:0]      tick_period,
  output logic [ADDR_W-1:0]      chart_addr,
  input  logic [LANES-1:0]       chart_data,
  input  logic [LANES-1:0]       hit,
  input  logic                   ack,
`ifdef NOTE_SCROLL_PAUSE_EN
  input  logic                   pause,
`endif
  output logic [DEPTH*LANES-1:0] note_map,
  output logic [OFFSET_W-1:0]    offset,
  output logic                   judge_hit,
  output logic                   judge_miss,
  output logic [COMBO_W-1:0]     combo,
  output logic                   busy,
  output logic                   finish
);

  localparam int CNT_W = $clog2(LANES + 1);
  localparam int SUM_W = COMBO_W + CNT_W;
  localparam logic [OFFSET_W-1:0] OFF_LAST = OFFSET_W'(SUBSTEPS - 1);

  function automatic logic [CNT_W-1:0] popcount(input logic [LANES-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < LANES; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  function automatic logic [COMBO_W-1:0] sat_add(input logic [COMBO_W-1:0] a,
                                                 input logic [CNT_W-1:0]   n);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(n);
    return (|s[SUM_W-1:COMBO_W]) ? '1 : s[COMBO_W-1:0];
  endfunction

  scroll_state_e        state_q;
  logic [ADDR_W-1:0]    len_q;
  logic [TICK_W-1:0]    period_q;
  logic [TICK_W-1:0]    tick_q;
  logic [OFFSET_W-1:0]  offset_q;
  logic [ADDR_W-1:0]    step_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [LANES-1:0]     next_step_q;
  logic                 refill_q;
  logic [COMBO_W-1:0]   combo_q;
  logic                 judge_hit_q;
  logic                 judge_miss_q;
  logic                 busy_q;
  logic                 finish_q;

  logic                 paused;
  logic                 run_en;
  logic                 tick_term;
  logic                 shift_en;
  logic                 win_clr;
  logic [LANES-1:0]     ins_step;
  logic [LANES-1:0]     hit_mask;
  logic                 miss;
  logic                 win_empty;

`ifdef NOTE_SCROLL_PAUSE_EN
  assign paused = pause;
`else
  assign paused = 1'b0;
`endif

  assign run_en    = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && !paused;
  assign tick_term = (tick_q == period_q);
  assign shift_en  = run_en && tick_term && (offset_q == OFF_LAST);
  assign win_clr   = ((state_q == ST_IDLE) && start) || ((state_q == ST_DONE) && ack);

  // A refill still pending at shift time means ROM data is the step to insert.
  always_comb begin
    ins_step = '0;
    if (state_q == ST_RUN) begin
      ins_step = refill_q ? chart_data : next_step_q;
    end
  end

  note_window_shift #(
    .LANES (LANES),
    .DEPTH (DEPTH),
    .JUDGE (JUDGE)
  ) u_window (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (win_clr),
    .hit_en_i   (run_en),
    .hit_i      (hit),
    .shift_i    (shift_en),
    .ins_i      (ins_step),
    .win_o      (note_map),
    .hit_mask_o (hit_mask),
    .miss_o     (miss),
    .empty_o    (win_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tick_q       <= '0;
      offset_q     <= '0;
      step_q       <= '0;
      addr_q       <= '0;
      refill_q     <= 1'b0;
      combo_q      <= '0;
      judge_hit_q  <= 1'b0;
      judge_miss_q <= 1'b0;
      busy_q       <= 1'b0;
      finish_q     <= 1'b0;
    end else begin
      judge_hit_q  <= 1'b0;
      judge_miss_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            len_q    <= chart_len;
            period_q <= tick_period;
            combo_q  <= '0;
            addr_q   <= '0;
            tick_q   <= '0;
            offset_q <= '0;
            step_q   <= '0;
            refill_q <= 1'b0;
            if (chart_len == '0) begin
              state_q  <= ST_DONE;
              finish_q <= 1'b1;
            end else begin
              state_q <= ST_PRIME;
              busy_q  <= 1'b1;
            end
          end
        end
        // ROM has been presenting address 0 since IDLE, so step 0 is ready now.
        ST_PRIME: begin
          next_step_q <= chart_data;
          addr_q      <= addr_q + 1'b1;
          state_q     <= ST_RUN;
        end
        ST_RUN, ST_DRAIN: begin
          if (run_en) begin
            if (tick_term) begin
              tick_q   <= '0;
              offset_q <= (offset_q == OFF_LAST) ? '0 : offset_q + 1'b1;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
            if (refill_q) begin
              next_step_q <= chart_data;
              refill_q    <= 1'b0;
            end
            if (shift_en && (state_q == ST_RUN)) begin
              step_q   <= step_q + 1'b1;
              addr_q   <= addr_q + 1'b1;
              refill_q <= 1'b1;
              if (step_q + 1'b1 == len_q) begin
                state_q <= ST_DRAIN;
              end
            end
            judge_hit_q  <= |hit_mask;
            judge_miss_q <= miss;
            combo_q      <= miss ? '0 : sat_add(combo_q, popcount(hit_mask));
            if ((state_q == ST_DRAIN) && win_empty) begin
              state_q  <= ST_DONE;
              busy_q   <= 1'b0;
              finish_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (ack) begin
            state_q  <= ST_IDLE;
            finish_q <= 1'b0;
            addr_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign chart_addr = addr_q;
  assign offset     = offset_q;
  assign judge_hit  = judge_hit_q;
  assign judge_miss = judge_miss_q;
  assign combo      = combo_q;
  assign busy       = busy_q;
  assign finish     = finish_q;

endmodule

// File: tb/tb_note_lane_scroller.sv
// Scoreboard bench for note_lane_scroller: stimulus queues expected judge events,
// a monitor checks every judge pulse against them; directed checks cover the rest.
module tb_note_lane_scroller;
  import note_scroll_pkg::*;

  localparam int LANES  = 2;
  localparam int DEPTH  = 10;
  localparam int JUDGE  = 1;
  localparam int ADDR_W = 11;
  localparam int TICK_W = 17;
  localparam int CW     = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [ADDR_W-1:0]      chart_len;
  logic [TICK_W-1:0]      tick_period;
  logic [ADDR_W-1:0]      chart_addr;
  logic [LANES-1:0]       chart_data;
  logic [LANES-1:0]       hit;
  logic                   ack;
`ifdef NOTE_SCROLL_PAUSE_EN
  logic                   pause;
`endif
  logic [DEPTH*LANES-1:0] note_map;
  logic [2:0]             offset;
  logic                   judge_hit;
  logic                   judge_miss;
  logic [CW-1:0]          combo;
  logic                   busy;
  logic                   finish;

  logic [LANES-1:0] rom [0:(1<<ADDR_W)-1];

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) chart_data <= rom[chart_addr];

  note_lane_scroller #(
    .LANES(LANES), .DEPTH(DEPTH), .SUBSTEPS(7), .JUDGE(JUDGE),
    .ADDR_W(ADDR_W), .TICK_W(TICK_W), .COMBO_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .chart_len(chart_len),
    .tick_period(tick_period), .chart_addr(chart_addr), .chart_data(chart_data),
    .hit(hit), .ack(ack),
`ifdef NOTE_SCROLL_PAUSE_EN
    .pause(pause),
`endif
    .note_map(note_map), .offset(offset), .judge_hit(judge_hit),
    .judge_miss(judge_miss), .combo(combo), .busy(busy), .finish(finish)
  );

  // Monitor: every judge pulse must match the next queued {hit, miss, combo}.
  always @(negedge clk) begin
    if (!rst && (judge_hit || judge_miss)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event got hit=%0d miss=%0d combo=%0d want no event",
                 judge_hit, judge_miss, combo);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if ({judge_hit, judge_miss, combo} !== e) begin
          bad++;
          $display("FAIL judge_event got hit=%0d miss=%0d combo=%0d want hit=%0d miss=%0d combo=%0d",
                   judge_hit, judge_miss, combo, e[3], e[2], e[1:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = '0;
  endtask

  task automatic start_song(input int len, input int period);
    chart_len   = ADDR_W'(len);
    tick_period = TICK_W'(period);
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_bit(input string name, input int idx, input int maxc);
    int n;
    n = 0;
    while (note_map[idx] !== 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (n >= maxc) begin
      total++; bad++;
      $display("FAIL %s timeout after %0d cycles, bit %0d never set", name, n, idx);
    end
  endtask

  task automatic wait_finish(input string name, input int maxc);
    int n;
    n = 0;
    while (finish !== 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (n >= maxc) begin
      total++; bad++;
      $display("FAIL %s timeout after %0d cycles, finish=%0d want 1", name, n, finish);
    end
  endtask

  task automatic pulse_hit(input logic [LANES-1:0] m);
    hit = m;
    @(negedge clk);
    hit = '0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  // Cycles between a note's arrival in row 9 and its move to row 8.
  task automatic measure_row(input string name, input int want);
    int n;
    wait_bit({name, "_row9"}, cell_bit(DEPTH-1, 0, LANES), 100);
    n = 0;
    while (note_map[cell_bit(DEPTH-2, 0, LANES)] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, n, want);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; chart_len = '0; tick_period = '0; hit = '0; ack = 1'b0;
`ifdef NOTE_SCROLL_PAUSE_EN
    pause = 1'b0;
`endif
    clear_rom();
    repeat (3) @(negedge clk);
    check("rst_note_map", 32'(note_map), 0);
    check("rst_offset", 32'(offset), 0);
    check("rst_combo", 32'(combo), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_finish", 32'(finish), 0);
    check("rst_addr", 32'(chart_addr), 0);
    rst = 1'b0;
    @(negedge clk);

    // Hit while idle is ignored.
    pulse_hit(2'b01);
    check("idle_hit_pulse", 32'(judge_hit), 0);
    check("idle_hit_combo", 32'(combo), 0);

    // Chart {01,00,10}, no hits: two misses, finish held until ack.
    rom[0] = 2'b01; rom[1] = 2'b00; rom[2] = 2'b10;
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0100);
    start_song(3, 0);
    check("prime_busy", 32'(busy), 1);
    measure_row("row_period_t0", 7);
    wait_finish("miss_song_done", 300);
    check("miss_combo", 32'(combo), 0);
    check("miss_busy_done", 32'(busy), 0);
    check("done_map_empty", 32'(note_map), 0);
    repeat (5) @(negedge clk);
    check("finish_held", 32'(finish), 1);
    pulse_ack();
    check("ack_finish", 32'(finish), 0);

    // Same chart with hits, plus a hit on an empty judge cell.
    start_song(3, 0);
    wait_bit("hit_lane0_wait", cell_bit(JUDGE, 0, LANES), 200);
    pulse_hit(2'b10);
    exp_q.push_back(4'b1001);
    pulse_hit(2'b01);
    check("hit_cleared_cell", 32'(note_map[cell_bit(JUDGE, 0, LANES)]), 0);
    wait_bit("hit_lane1_wait", cell_bit(JUDGE, 1, LANES), 200);
    exp_q.push_back(4'b1010);
    pulse_hit(2'b10);
    wait_finish("hit_song_done", 300);
    check("hit_combo", 32'(combo), 2);
    pulse_ack();

    // Saturation: six lane-0 notes, hit five, let the sixth pass.
    clear_rom();
    for (int i = 0; i < 6; i++) rom[i] = 2'b01;
    start_song(6, 1);
    measure_row("row_period_t1", 14);
    for (int k = 0; k < 5; k++) begin
      wait_bit("sat_wait", cell_bit(JUDGE, 0, LANES), 200);
      exp_q.push_back({2'b10, (k < 3) ? 2'(k + 1) : 2'd3});
      pulse_hit(2'b01);
    end
    exp_q.push_back(4'b0100);
    wait_finish("sat_song_done", 500);
    check("sat_combo_after_miss", 32'(combo), 0);
    pulse_ack();

    // Zero-length chart goes straight to DONE.
    start_song(0, 0);
    check("empty_chart_finish", 32'(finish), 1);
    check("empty_chart_busy", 32'(busy), 0);
    pulse_ack();

`ifdef NOTE_SCROLL_PAUSE_EN
    begin
      logic [DEPTH*LANES-1:0] map_s;
      logic [2:0]             off_s;
      clear_rom();
      rom[0] = 2'b01; rom[1] = 2'b00; rom[2] = 2'b10;
      exp_q.push_back(4'b0100);
      exp_q.push_back(4'b0100);
      start_song(3, 2);
      repeat (40) @(negedge clk);
      map_s = note_map;
      off_s = offset;
      pause = 1'b1;
      repeat (20) @(negedge clk);
      check("pause_offset", 32'(offset), 32'(off_s));
      check("pause_map", 32'(note_map), 32'(map_s));
      pause = 1'b0;
      wait_finish("pause_song_done", 600);
      pulse_ack();
    end
`endif

    // Reset in the middle of a song.
    clear_rom();
    rom[0] = 2'b01; rom[1] = 2'b00; rom[2] = 2'b10;
    start_song(3, 0);
    wait_bit("rst_run_wait", cell_bit(JUDGE, 0, LANES), 200);
    exp_q.push_back(4'b1001);
    pulse_hit(2'b01);
    repeat (3) @(negedge clk);
    check("pre_rst_combo", 32'(combo), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_note_map", 32'(note_map), 0);
    check("midrst_offset", 32'(offset), 0);
    check("midrst_combo", 32'(combo), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_finish", 32'(finish), 0);
    repeat (30) @(negedge clk);

    check("events_left", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
